// File: rtl/stream_mux_rr.sv
// stream_mux_rr: NUM_IN-way registered valid/ready stream mux, fixed-select or round-robin.
// Define STREAM_MUX_PKT_LOCK_EN to hold the grant on one channel until its in_last beat.
module stream_mux_rr #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    localparam int SELW  = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode_rr,
    input  logic [SELW-1:0]         sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN-1:0]       in_last,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [SELW-1:0]         out_sel,
    input  logic                    out_ready
);

    localparam logic [SELW:0]   NUM_W    = (SELW+1)'(NUM_IN);
    localparam logic [SELW-1:0] LAST_IDX = SELW'(NUM_IN - 1);

    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_last;
    logic [SELW-1:0]   r_out_sel;
    logic [SELW-1:0]   r_ptr;

    logic [WIDTH-1:0]  w_ch_data [NUM_IN];
    logic              w_load_en;
    logic [NUM_IN-1:0] w_rr_hi;
    logic [NUM_IN-1:0] w_rr_src;
    logic              w_rr_found;
    logic [SELW-1:0]   w_rr_idx;
    logic              w_gnt_any;
    logic [SELW-1:0]   w_gnt_idx;
    logic              w_gnt_last;
    logic              w_xfer;
    logic [SELW-1:0]   w_ptr_next_g;
    logic              w_adv_ptr;
    logic              w_locked;
    logic [SELW-1:0]   w_lock_idx;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
        assign w_ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign w_load_en = !r_out_valid || out_ready;

    // Prefer valid channels at or above ptr; fall back to the lowest valid one (wrap).
    always_comb begin
        w_rr_hi = '0;
        for (int i = 0; i < NUM_IN; i++)
            w_rr_hi[i] = in_valid[i] && (SELW'(i) >= r_ptr);
        w_rr_src   = (|w_rr_hi) ? w_rr_hi : in_valid;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_rr_src[i] && !w_rr_found) begin
                w_rr_found = 1'b1;
                w_rr_idx   = SELW'(i);
            end
        end
    end

    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        if (w_locked) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = w_lock_idx;
        end else if (mode_rr) begin
            w_gnt_any = w_rr_found;
            w_gnt_idx = w_rr_idx;
        end else if ({1'b0, sel} < NUM_W) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = sel;
        end
    end

    assign w_gnt_last   = in_last[w_gnt_idx];
    assign w_xfer       = w_gnt_any && in_valid[w_gnt_idx] && w_load_en && rst_n;
    assign w_ptr_next_g = (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + 1'b1;

    always_comb begin
        in_ready = '0;
        if (w_gnt_any && w_load_en && rst_n)
            in_ready[w_gnt_idx] = 1'b1;
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SELW-1:0] r_lock_idx;
    logic [SELW-1:0] w_lock_idx_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_idx <= w_lock_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_idx_nxt = r_lock_idx;
        unique case (r_state)
            S_IDLE: begin
                if (w_xfer && !w_gnt_last) begin
                    w_state_nxt    = S_LOCKED;
                    w_lock_idx_nxt = w_gnt_idx;
                end
            end
            S_LOCKED: begin
                if (w_xfer && w_gnt_last)
                    w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_locked   = (r_state == S_LOCKED);
    assign w_lock_idx = r_lock_idx;
    // Pointer moves only once a packet has completed.
    assign w_adv_ptr  = w_xfer && mode_rr && w_gnt_last;
`else
    assign w_locked   = 1'b0;
    assign w_lock_idx = '0;
    assign w_adv_ptr  = w_xfer && mode_rr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_load_en) begin
                r_out_valid <= w_xfer;
                if (w_xfer) begin
                    r_out_data <= w_ch_data[w_gnt_idx];
                    r_out_last <= w_gnt_last;
                    r_out_sel  <= w_gnt_idx;
                end
            end
            if (w_adv_ptr)
                r_ptr <= w_ptr_next_g;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: vector table, hand sequences and randomized run against a
// behavioural model for stream_mux_rr (plus a 3-input instance for sel range).
module tb_stream_mux_rr;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           mode_rr;
    logic [SW-1:0]  sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_last;
    logic [SW-1:0]  out_sel;
    logic           out_ready;

    logic           mode3;
    logic [1:0]     sel3;
    logic [3*W-1:0] data3;
    logic [2:0]     valid3;
    logic [2:0]     last3;
    logic [2:0]     ready3;
    logic [W-1:0]   odata3;
    logic           ovalid3;
    logic           olast3;
    logic [1:0]     osel3;
    logic           ordy3;

    int n_pass  = 0;
    int n_total = 0;

    bit m_ov;
    bit [W-1:0] m_data;
    bit m_last;
    int m_sel;
    int m_ptr;
    bit m_lk;
    int m_lg;

    typedef struct {
        logic [SW-1:0]  sel;
        logic [N-1:0]   valid;
        logic [N*W-1:0] data;
        logic           ordy;
        logic [N-1:0]   e_rdy;
        logic           e_ov;
        logic [SW-1:0]  e_sel;
        logic [W-1:0]   e_data;
    } vec_t;

    vec_t tbl [6];

    stream_mux_rr #(.WIDTH(W), .NUM_IN(N)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode_rr(mode_rr), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_sel(out_sel), .out_ready(out_ready)
    );

    stream_mux_rr #(.WIDTH(W), .NUM_IN(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .mode_rr(mode3), .sel(sel3),
        .in_data(data3), .in_valid(valid3), .in_last(last3),
        .in_ready(ready3), .out_data(odata3), .out_valid(ovalid3),
        .out_last(olast3), .out_sel(osel3), .out_ready(ordy3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic idle_inputs();
        mode_rr = 1'b0; sel = '0; in_data = '0; in_valid = '0;
        in_last = '0; out_ready = 1'b1;
        mode3 = 1'b0; sel3 = '0; data3 = '0; valid3 = '0;
        last3 = 3'b111; ordy3 = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_ov = 0; m_data = '0; m_last = 0; m_sel = 0;
        m_ptr = 0; m_lk = 0; m_lg = 0;
    endtask

    // Grant from the rules: locked channel, else explicit sel, else scan from ptr.
    task automatic model_grant(output bit any, output int g);
        any = 0;
        g = 0;
        if (m_lk) begin
            any = 1; g = m_lg;
        end else if (mode_rr) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!any && in_valid[c]) begin any = 1; g = c; end
            end
        end else if (int'(sel) < N) begin
            any = 1; g = int'(sel);
        end
    endtask

    task automatic rand_cycle();
        bit any, le, xf;
        int g;
        logic [N-1:0] e_rdy;
        if ($urandom_range(0, 7) == 0) mode_rr = ~mode_rr;
        sel       = SW'($urandom_range(0, N-1));
        in_valid  = N'($urandom);
        in_last   = N'($urandom);
        in_data   = (N*W)'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        model_grant(any, g);
        le    = !m_ov || out_ready;
        e_rdy = (any && le) ? (N'(1) << g) : '0;
        chk("rand_in_ready", in_ready, e_rdy);
        xf = any && le && in_valid[g];
        @(posedge clk);
        #1;
        if (le) begin
            m_ov = xf;
            if (xf) begin
                m_data = in_data[g*W +: W];
                m_last = in_last[g];
                m_sel  = g;
            end
        end
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (xf) begin
            if (!m_lk) begin
                if (!in_last[g]) begin m_lk = 1; m_lg = g; end
                else if (mode_rr) m_ptr = (g + 1) % N;
            end else if (in_last[g]) begin
                m_lk = 0;
                if (mode_rr) m_ptr = (g + 1) % N;
            end
        end
`else
        if (xf && mode_rr) m_ptr = (g + 1) % N;
`endif
        chk("rand_out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("rand_out_data", out_data, m_data);
            chk("rand_out_sel", out_sel, m_sel);
            chk("rand_out_last", out_last, m_last);
        end
    endtask

    initial begin
        int exp_s [5];
        int lk_sel [4];
        int lk_dat [4];
        int c0;
        bit r0;

        tbl[0] = '{2'd2, 4'hF, 32'h33A51100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
        tbl[1] = '{2'd0, 4'hE, 32'h33A51100, 1'b1, 4'b0001, 1'b0, 2'd2, 8'hA5};
        tbl[2] = '{2'd3, 4'h8, 32'h5A000000, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h5A};
        tbl[3] = '{2'd1, 4'h2, 32'h0000C300, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hC3};
        tbl[4] = '{2'd1, 4'h2, 32'h0000FF00, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hC3};
        tbl[5] = '{2'd1, 4'h2, 32'h0000FF00, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hFF};

        idle_inputs();
        in_valid = 4'hF; sel = 2'd2;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        do_reset();

        for (int i = 0; i < 6; i++) begin
            mode_rr = 1'b0; sel = tbl[i].sel; in_valid = tbl[i].valid;
            in_last = 4'hF; in_data = tbl[i].data; out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
            if (tbl[i].e_ov) begin
                chk($sformatf("tbl%0d_out_sel", i), out_sel, tbl[i].e_sel);
                chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_data);
                chk($sformatf("tbl%0d_out_last", i), out_last, 1);
            end
        end

        // Async reset mid-cycle while a beat is held
        sel = 2'd2; in_valid = 4'hF; in_data = 32'h33A51100;
        #3;
        rst_n = 1'b0;
        #1;
        chk("amid_out_valid", out_valid, 0);
        chk("amid_out_sel", out_sel, 0);
        chk("amid_out_data", out_data, 0);
        chk("amid_in_ready", in_ready, 0);
        do_reset();

        // Out-of-range select on the 3-input instance
        sel3 = 2'd3; valid3 = 3'b111; data3 = 24'hC2B1A0;
        #1;
        chk("n3_oor_ready", ready3, 0);
        @(posedge clk);
        #1;
        chk("n3_oor_valid", ovalid3, 0);
        sel3 = 2'd2;
        #1;
        chk("n3_sel2_ready", ready3, 3'b100);
        @(posedge clk);
        #1;
        chk("n3_sel2_valid", ovalid3, 1);
        chk("n3_sel2_data", odata3, 8'hC2);
        chk("n3_sel2_sel", osel3, 2);

        // Round-robin, all channels valid
        do_reset();
        mode_rr = 1'b1; in_valid = 4'hF; in_last = 4'hF; in_data = 32'h44332211;
        exp_s = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rr_all_sel%0d", k), out_sel, exp_s[k]);
            chk($sformatf("rr_all_valid%0d", k), out_valid, 1);
        end

        // Round-robin skip and wrap with ch1, ch3 only
        do_reset();
        mode_rr = 1'b1; in_valid = 4'b1010; in_last = 4'hF; in_data = 32'h44332211;
        exp_s = '{1, 3, 1, 3, 1};
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rr_skip_sel%0d", k), out_sel, exp_s[k]);
        end

        // Backpressure: output must hold, nothing accepted, then resume on ch1
        do_reset();
        mode_rr = 1'b1; in_valid = 4'hF; in_last = 4'hF; in_data = 32'h44332211;
        @(posedge clk);
        #1;
        chk("bp_first_sel", out_sel, 0);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp_in_ready%0d", k), in_ready, 0);
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold_valid%0d", k), out_valid, 1);
            chk($sformatf("bp_hold_sel%0d", k), out_sel, 0);
            chk($sformatf("bp_hold_data%0d", k), out_data, 8'h11);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 4'b0010);
        @(posedge clk);
        #1;
        chk("bp_next_sel", out_sel, 1);
        chk("bp_next_data", out_data, 8'h22);

        // Packet on ch0 (3 beats) competing with ch1
        do_reset();
`ifdef STREAM_MUX_PKT_LOCK_EN
        lk_sel = '{0, 0, 0, 1};
        lk_dat = '{8'h10, 8'h11, 8'h12, 8'h20};
`else
        lk_sel = '{0, 1, 0, 1};
        lk_dat = '{8'h10, 8'h20, 8'h11, 8'h20};
`endif
        c0 = 0;
        mode_rr = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = {2'b00, 1'b1, (c0 < 3)};
            in_last  = {3'b111, (c0 == 2)};
            in_data  = {16'h0000, 8'h20, W'(8'h10 + c0)};
            #1;
            r0 = in_ready[0];
            @(posedge clk);
            #1;
            chk($sformatf("pkt_sel%0d", k), out_sel, lk_sel[k]);
            chk($sformatf("pkt_data%0d", k), out_data, lk_dat[k]);
            if (r0) c0++;
        end

        // Randomized run against the model
        do_reset();
        mode_rr = 1'b1;
        for (int k = 0; k < 400; k++) rand_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
